tt_sweep_checker: RTL and testbench

TT_SWEEP_CHECKER -- requirements
Module: tt_sweep_checker

---
 rtl/tt_sweep_checker.sv | 157 +++++++++++++++
 tb/tb_tt_sweep_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: exhaustive truth-table sweep of a combinational DUT.
// The block drives every input pattern 0 .. 2**N_IN-1 onto stim and holds each
// one for HOLD cycles. On the last cycle of each hold it samples dut_f and
// compares it with EXPECT[pattern]. It counts mismatches and records the first
// failing pattern.
// The optional feature is controlled by the macro TT_SWEEP_STOP_ON_ERR_EN.
// When it is defined, the first mismatch ends the sweep immediately.

module tt_sweep_checker #(
    parameter int                    N_IN   = 4,
    parameter int                    HOLD   = 2,
    parameter logic [2**N_IN-1:0]    EXPECT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   stim,
    input  logic              dut_f,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_cnt,
    output logic [N_IN-1:0]   first_err_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Value of hold_cnt on the cycle where dut_f is sampled.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [N_IN-1:0]     r_idx;
    logic [7:0]          r_hold_cnt;
    logic [N_IN-1:0]     r_stim;
    logic [N_IN:0]       r_err_cnt;
    logic [N_IN-1:0]     r_first_err_idx;
    logic                r_pass;

    logic                w_sample;
    logic                w_mismatch;
    logic                w_last;
    logic                w_to_done;
    logic [N_IN:0]       w_err_cnt_nxt;
    logic                w_busy;
    logic                w_done;

    // The sample point is the last cycle of the current pattern's hold window.
    assign w_sample      = (r_state == APPLY) && (r_hold_cnt == HOLD_LAST);
    assign w_mismatch    = w_sample && (dut_f != EXPECT[r_idx]);
    assign w_last        = (r_idx == {N_IN{1'b1}});
    assign w_err_cnt_nxt = r_err_cnt + {{N_IN{1'b0}}, w_mismatch};

`ifdef TT_SWEEP_STOP_ON_ERR_EN
    // The first mismatch aborts the sweep. err_cnt can only reach 1.
    assign w_to_done = w_sample && (w_last || w_mismatch);
`else
    // The sweep always covers every pattern.
    assign w_to_done = w_sample && w_last;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = APPLY;
            APPLY:   if (w_to_done) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Status outputs are decoded directly from the state.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            APPLY:   w_busy = 1'b1;
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    // Sweep datapath: pattern index, hold timer, registered stimulus and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx           <= '0;
            r_hold_cnt      <= '0;
            r_stim          <= '0;
            r_err_cnt       <= '0;
            r_first_err_idx <= '0;
            r_pass          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // The results of the previous sweep stay visible until a new start is accepted.
                    if (start) begin
                        r_idx           <= '0;
                        r_hold_cnt      <= '0;
                        r_stim          <= '0;
                        r_err_cnt       <= '0;
                        r_first_err_idx <= '0;
                        r_pass          <= 1'b0;
                    end
                end
                APPLY: begin
                    if (w_sample) begin
                        r_err_cnt <= w_err_cnt_nxt;
                        if (w_mismatch && (r_err_cnt == '0)) begin
                            r_first_err_idx <= r_idx;
                        end
                        if (w_to_done) begin
                            // This includes a mismatch on the final pattern in the verdict.
                            r_stim <= '0;
                            r_pass <= (w_err_cnt_nxt == '0);
                        end else begin
                            r_idx      <= r_idx + N_IN'(1);
                            r_stim     <= r_idx + N_IN'(1);
                            r_hold_cnt <= '0;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                DONE: begin
                    r_idx      <= '0;
                    r_hold_cnt <= '0;
                    r_stim     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign stim          = r_stim;
    assign busy          = w_busy;
    assign done          = w_done;
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Testbench for tt_sweep_checker.
// The main instance uses N_IN=4, HOLD=2, EXPECT=16'h8000. The emulated DUT is a
// truth table indexed by stim. A second instance uses N_IN=2, HOLD=1,
// EXPECT=4'b0110, driven by an XOR.
// Latency is the number of the rising edge after the start edge that first
// captures done high.

module tb_tt_sweep_checker;

    localparam int          N    = 4;
    localparam int          HOLD = 2;
    localparam int          NPAT = 16;
    localparam logic [15:0] EXP  = 16'h8000;

`ifdef TT_SWEEP_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  stim;
    logic        dut_f;
    logic        busy, done, pass;
    logic [4:0]  err_cnt;
    logic [3:0]  first_err_idx;
    logic [15:0] dut_tt;

    logic        start2;
    logic [1:0]  stim2;
    logic        dut_f2;
    logic        busy2, done2, pass2;
    logic [2:0]  err_cnt2;
    logic [1:0]  first_err_idx2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign dut_f  = dut_tt[stim];
    assign dut_f2 = stim2[1] ^ stim2[0];

    tt_sweep_checker #(.N_IN(N), .HOLD(HOLD), .EXPECT(EXP)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stim          (stim),
        .dut_f         (dut_f),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx)
    );

    tt_sweep_checker #(.N_IN(2), .HOLD(1), .EXPECT(4'b0110)) u_dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start2),
        .stim          (stim2),
        .dut_f         (dut_f2),
        .busy          (busy2),
        .done          (done2),
        .pass          (pass2),
        .err_cnt       (err_cnt2),
        .first_err_idx (first_err_idx2)
    );

    typedef struct {
        logic [15:0] tt;
        int          err;
        int          first;
        bit          pass;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference model: derives the sweep results from the truth-table difference.
    task automatic model(input logic [15:0] tt, output int err, output int first,
                         output bit ok, output int lat);
        logic [15:0] diff;
        diff  = tt ^ EXP;
        err   = 0;
        first = 0;
        for (int i = NPAT - 1; i >= 0; i--) begin
            if (diff[i]) begin
                err++;
                first = i;
            end
        end
        if (STOP && err > 0) begin
            err = 1;
            lat = HOLD * (first + 1) + 1;
        end else begin
            lat = NPAT * HOLD + 1;
        end
        ok = (err == 0);
    endtask

    // This task runs one sweep and checks the stimulus sequence, the latency and the results.
    // It returns at the negedge following the done cycle.
    task automatic run_sweep(input string tag, input logic [15:0] tt, input bit hold_start,
                             input int exp_err, input int exp_first, input bit exp_pass,
                             input int exp_lat);
        int lat;
        int stim_bad;
        lat      = 0;
        stim_bad = 0;
        dut_tt   = tt;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) start = hold_start;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (busy !== 1'b1 || stim !== 4'((n - 1) / HOLD)) stim_bad++;
        end
        check({tag, "_latency"},  lat, exp_lat);
        check({tag, "_stim_seq"}, stim_bad, 0);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_stim_done"}, stim, 0);
        check({tag, "_err_cnt"},  err_cnt, exp_err);
        check({tag, "_first"},    first_err_idx, exp_first);
        check({tag, "_pass"},     pass, exp_pass);
        @(negedge clk);
        check({tag, "_done_1cyc"}, done, 0);
        check({tag, "_err_held"}, err_cnt, exp_err);
        check({tag, "_pass_held"}, pass, exp_pass);
    endtask

    // This helper waits a bounded time for done and then steps past it.
    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs[5];
        int   e_err, e_first, e_lat;
        bit   e_pass;
        logic [15:0] rtt;

        vecs[0] = '{tt: 16'h8000, err: 0,  first: 0,  pass: 1'b1};  // AND4
        vecs[1] = '{tt: 16'h0000, err: 1,  first: 15, pass: 1'b0};  // stuck at 0
        vecs[2] = '{tt: 16'h7FFF, err: 16, first: 0,  pass: 1'b0};  // NAND4
        vecs[3] = '{tt: 16'hFFFF, err: 15, first: 0,  pass: 1'b0};  // stuck at 1
        vecs[4] = '{tt: 16'h8020, err: 1,  first: 5,  pass: 1'b0};  // single fault mid-table

        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        dut_tt = 16'h8000;
        #1;
        check("reset_stim",  stim, 0);
        check("reset_busy",  busy, 0);
        check("reset_done",  done, 0);
        check("reset_pass",  pass, 0);
        check("reset_err",   err_cnt, 0);
        check("reset_first", first_err_idx, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sweeps. Table values assume full coverage.
        // In abort mode the expected count is capped at one and the latency shortens.
        for (int v = 0; v < 5; v++) begin
            e_err   = vecs[v].err;
            e_first = vecs[v].first;
            e_pass  = vecs[v].pass;
            e_lat   = NPAT * HOLD + 1;
            if (STOP && e_err > 0) begin
                e_err = 1;
                e_lat = HOLD * (e_first + 1) + 1;
            end
            run_sweep($sformatf("vec%0d", v), vecs[v].tt, 1'b0, e_err, e_first, e_pass, e_lat);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_idle_hold", v), err_cnt, e_err);
        end

        // Randomized truth tables are checked against the reference model.
        for (int k = 0; k < 8; k++) begin
            if (k[0]) rtt = EXP ^ (16'h1 << $urandom_range(15, 0));
            else      rtt = 16'($urandom);
            model(rtt, e_err, e_first, e_pass, e_lat);
            run_sweep($sformatf("rand%0d", k), rtt, 1'b0, e_err, e_first, e_pass, e_lat);
        end

        // Hold start high through the sweep. Only one sweep may run, and the next
        // one may begin only from IDLE.
        run_sweep("hold_start", 16'h8000, 1'b1, 0, 0, 1'b1, NPAT * HOLD + 1);
        check("no_queue_idle", busy, 0);
        @(negedge clk);
        check("restart_from_idle", busy, 1);
        start = 1'b0;
        wait_done("restart");

        // Assert reset 10 cycles into a sweep that already has a mismatch.
        dut_tt = 16'h8004;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_stim",  stim, 0);
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_done",  done, 0);
        check("mid_rst_pass",  pass, 0);
        check("mid_rst_err",   err_cnt, 0);
        check("mid_rst_first", first_err_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep("post_rst", 16'h8000, 1'b0, 0, 0, 1'b1, NPAT * HOLD + 1);

        // Small configuration: N_IN=2, HOLD=1, with an XOR as the DUT.
        begin
            int lat2;
            lat2 = 0;
            @(negedge clk);
            start2 = 1'b1;
            for (int n = 1; n <= 50; n++) begin
                @(negedge clk);
                if (n == 1) start2 = 1'b0;
                if (done2 === 1'b1) begin
                    lat2 = n;
                    break;
                end
            end
            check("xor_latency", lat2, 5);
            check("xor_pass",    pass2, 1);
            check("xor_err",     err_cnt2, 0);
            check("xor_first",   first_err_idx2, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
